// File: rtl/btn_evt_pkg.sv
// Shared state encoding and default parameter values for button_event_gen.
package btn_evt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHORT = 2'd1,
      LONG  = 2'd2
   } state_t;

   localparam int DEF_LONG_CYCLES   = 1024;
   localparam int DEF_REPEAT_CYCLES = 256;
   localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/button_event_gen_if.sv
// Button level and event strobes bundled for hookup to button_event_gen.
interface button_event_gen_if;

   logic db_in;
   logic pressed;
   logic press_pulse;
   logic release_pulse;
   logic short_pulse;
   logic long_pulse;
   logic repeat_pulse;

   modport master (
      output db_in,
      input  pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
   );

   modport slave (
      input  db_in,
      output pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
   );

endinterface

// File: rtl/button_event_gen.sv
// Press / short / long / auto-repeat event generator for a debounced button level.
// Define BUTTON_EVENT_AUTO_REPEAT_EN to enable repeat strobes while held long.
module button_event_gen
   import btn_evt_pkg::*;
#(
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic n_reset,
   input  logic db_in,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
      $error("button_event_gen: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic repeat_q;
   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   // Release is tested before the terminal count so it always wins a tie.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state         <= IDLE;
         cnt           <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
         repeat_q      <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
         repeat_q      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (db_in) begin
                  state       <= SHORT;
                  cnt         <= '0;
                  pressed     <= 1'b1;
                  press_pulse <= 1'b1;
               end
            end
            SHORT: begin
               if (!db_in) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
                  short_pulse   <= 1'b1;
               end else if (cnt == LONG_LAST) begin
                  state      <= LONG;
                  cnt        <= '0;
                  long_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LONG: begin
               if (!db_in) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                  if (cnt == REPEAT_LAST) begin
                     cnt      <= '0;
                     repeat_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
`else
                  cnt <= '0;
`endif
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               pressed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_gen;
   import btn_evt_pkg::*;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
   localparam bit RPT = 1'b1;
`else
   localparam bit RPT = 1'b0;
`endif

   logic clk;
   logic n_reset;
   int   checks;
   int   failures;

   // Expected output vector per cycle: {pressed, press, release, short, long, repeat}
   logic [5:0] exp_q[$];

   button_event_gen_if bus ();

   button_event_gen #(
      .LONG_CYCLES  (8),
      .REPEAT_CYCLES(4),
      .CNT_W        (16)
   ) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .db_in        (bus.db_in),
      .pressed      (bus.pressed),
      .press_pulse  (bus.press_pulse),
      .release_pulse(bus.release_pulse),
      .short_pulse  (bus.short_pulse),
      .long_pulse   (bus.long_pulse),
      .repeat_pulse (bus.repeat_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] ev(input logic p, input logic pr, input logic rl,
                                     input logic sh, input logic lg, input logic rp);
      return {p, pr, rl, sh, lg, rp};
   endfunction

   function automatic logic [5:0] observed();
      return {bus.pressed, bus.press_pulse, bus.release_pulse,
              bus.short_pulse, bus.long_pulse, bus.repeat_pulse};
   endfunction

   task automatic test_reset();
      logic [5:0] got;
      n_reset   = 1'b0;
      bus.db_in = 1'b1;
      #1;
      got = observed();
      checks++;
      if (got !== 6'b0) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", got, 6'b0);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (got !== 6'b0) begin
            failures++;
            $display("FAIL reset_held cyc=%0d got=%b exp=%b", i, got, 6'b0);
         end
      end
      bus.db_in = 1'b0;
      n_reset   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== 6'b0) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=%b", got, 6'b0);
      end
   endtask

   task automatic test_short_press();
      logic stim[$];
      logic [5:0] got, exp;
      stim = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 1, 1, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
      foreach (stim[i]) begin
         bus.db_in = stim[i];
         @(posedge clk);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL short_press cyc=%0d got=%b exp=%b", i + 1, got, exp);
         end
      end
   endtask

   task automatic test_long_hold();
      logic [5:0] got, exp;
      for (int c = 1; c <= 22; c++) begin
         if (c == 1)       exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
         else if (c <= 20) exp_q.push_back(ev(1, 0, 0, 0, c == 9, RPT && (c == 13 || c == 17)));
         else if (c == 21) exp_q.push_back(ev(0, 0, 1, 0, 0, 0));
         else              exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
      end
      for (int c = 1; c <= 22; c++) begin
         bus.db_in = (c <= 20);
         @(posedge clk);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL long_hold cyc=%0d got=%b exp=%b", c, got, exp);
         end
      end
   endtask

   task automatic test_threshold_tie();
      logic [5:0] got, exp;
      // Release sampled on the terminal-count edge: short wins, no long.
      for (int c = 1; c <= 10; c++) begin
         if (c == 1)      exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
         else if (c <= 8) exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
         else if (c == 9) exp_q.push_back(ev(0, 0, 1, 1, 0, 0));
         else             exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
      end
      for (int c = 1; c <= 10; c++) begin
         bus.db_in = (c <= 8);
         @(posedge clk);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL tie_short cyc=%0d got=%b exp=%b", c, got, exp);
         end
      end
      // One cycle longer: long fires, release then carries no short.
      for (int c = 1; c <= 11; c++) begin
         if (c == 1)       exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
         else if (c <= 9)  exp_q.push_back(ev(1, 0, 0, 0, c == 9, 0));
         else if (c == 10) exp_q.push_back(ev(0, 0, 1, 0, 0, 0));
         else              exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
      end
      for (int c = 1; c <= 11; c++) begin
         bus.db_in = (c <= 9);
         @(posedge clk);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL tie_long cyc=%0d got=%b exp=%b", c, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic stim[$];
      logic [5:0] got, exp;
      // Single-cycle blip, then press / release / re-press with no idle gap.
      stim = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 1, 1, 0, 0));
      exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 1, 1, 0, 0));
      exp_q.push_back(ev(1, 1, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 1, 1, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
      foreach (stim[i]) begin
         bus.db_in = stim[i];
         @(posedge clk);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i + 1, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      logic [5:0] got, exp;
      for (int c = 1; c <= 5; c++)
         exp_q.push_back(ev(1, c == 1, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0));  // immediately on reset assertion
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0));  // edge during reset
      exp_q.push_back(ev(1, 1, 0, 0, 0, 0));  // first edge after deassertion
      exp_q.push_back(ev(0, 0, 1, 1, 0, 0));
      for (int c = 1; c <= 5; c++) begin
         bus.db_in = 1'b1;
         @(posedge clk);
         @(negedge clk);
         got = observed();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rst_mid_hold cyc=%0d got=%b exp=%b", c, got, exp);
         end
      end
      #2 n_reset = 1'b0;
      #1;
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL rst_mid_async got=%b exp=%b", got, exp);
      end
      @(posedge clk);
      @(negedge clk);
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL rst_mid_held got=%b exp=%b", got, exp);
      end
      n_reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL rst_mid_repress got=%b exp=%b", got, exp);
      end
      bus.db_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL rst_mid_release got=%b exp=%b", got, exp);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      n_reset   = 1'b0;
      bus.db_in = 1'b0;
      @(negedge clk);
      test_reset();
      test_short_press();
      test_long_hold();
      test_threshold_tie();
      test_back_to_back();
      test_reset_mid_press();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 1024, which is the number of clk cycles a press must be held to count as a long press (minimum 2).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 256, which is the auto-repeat period in clk cycles (minimum 2).
REQ-003 SHALL have parameter CNT_W, default 16, which is the hold-counter width; it must hold LONG_CYCLES-1 and REPEAT_CYCLES-1.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port n_reset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port db_in, input, 1 bit: debounced, clk-synchronous button level; 1 = pressed.
REQ-007 SHALL have port pressed, output, 1 bit: registered level, high while in SHORT or LONG.
REQ-008 SHALL have port press_pulse, output, 1 bit: one-cycle strobe on press.
REQ-009 SHALL have port release_pulse, output, 1 bit: one-cycle strobe on any release.
REQ-010 SHALL have port short_pulse, output, 1 bit: one-cycle strobe on a release that occurs before the long threshold.
REQ-011 SHALL have port long_pulse, output, 1 bit: one-cycle strobe when the long threshold is reached.
REQ-012 SHALL have port repeat_pulse, output, 1 bit: one-cycle strobe every REPEAT_CYCLES while held long.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHORT and LONG plus a CNT_W-bit hold counter cnt.
REQ-014 SHALL treat db_in as already synchronous; it adds no synchronizer stages.
REQ-015 In IDLE with db_in=1, SHALL go to SHORT, clear cnt and assert press_pulse.
REQ-016 In SHORT with db_in=0, SHALL go to IDLE and assert release_pulse and short_pulse in the same cycle.
REQ-017 In SHORT with db_in=1 and cnt==LONG_CYCLES-1, SHALL go to LONG, clear cnt and assert long_pulse; otherwise cnt increments.
REQ-018 In LONG with db_in=0, SHALL go to IDLE and assert release_pulse only, with no short_pulse.
REQ-019 In LONG with db_in=1, cnt SHALL count to REPEAT_CYCLES-1, then wrap to 0 and assert repeat_pulse.
REQ-020 All strobes SHALL be registered and high exactly one cycle, in the cycle after the edge that sampled the triggering db_in; latency is 1 clk.
REQ-021 If release coincides with the threshold cycle, release SHALL win: SHORT gives short_pulse with no long_pulse, and LONG gives no repeat_pulse.
REQ-022 cnt SHALL never exceed its terminal value; no overflow wrap is possible with legal parameters.
REQ-023 A one-cycle db_in high pulse SHALL produce press_pulse, then on the next cycle release_pulse and short_pulse.

Reset
REQ-024 n_reset=0 SHALL immediately set state to IDLE, cnt to 0, and all outputs (pressed and every strobe) to 0.
REQ-025 Reset asserted mid-press SHALL emit no release_pulse; after deassertion with db_in=1, a fresh press_pulse follows one cycle later.

Configuration
REQ-026 Macro BUTTON_EVENT_AUTO_REPEAT_EN defined SHALL enable the REQ-019 repeat behaviour.
REQ-027 Without the macro, repeat_pulse SHALL be tied to 0 and cnt SHALL hold at 0 in LONG; all other behaviour is unchanged.

Structure
REQ-028 Package btn_evt_pkg SHALL hold the state encoding (IDLE=0, SHORT=1, LONG=2, 2 bits) and the default parameter constants.
REQ-029 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-030 Holding db_in=1 for 3 cycles and then 0 SHALL give press_pulse at cycle 1 and release_pulse plus short_pulse at cycle 4, with no long_pulse.
REQ-031 Holding db_in=1 for 20 cycles SHALL give press_pulse at cycle 1 and long_pulse at cycle 9; with the macro, repeat_pulse at cycles 13 and 17; on release, release_pulse only.
REQ-032 Releasing on exactly the cycle cnt==7 SHALL give short_pulse and no long_pulse.
REQ-033 Asserting n_reset=0 at cycle 5 of a hold SHALL clear all outputs at once, with no release_pulse; when db_in stays 1 after deassertion, press_pulse follows one cycle after deassertion.
REQ-034 With the macro undefined, a 20-cycle hold SHALL never assert repeat_pulse and SHALL assert long_pulse exactly once.
